// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters,
// with a bounded lock so one port can issue back-to-back dependent ops.
module alu_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Lock0,
  input  logic        Lock1,
  input  logic [31:0] BusA0,
  input  logic [31:0] BusA1,
  input  logic [31:0] BusB0,
  input  logic [31:0] BusB1,
  input  logic [3:0]  ALUCtrl0,
  input  logic [3:0]  ALUCtrl1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Valid0,
  output logic        Valid1,
  output logic [31:0] BusW0,
  output logic [31:0] BusW1,
  output logic        Zero0,
  output logic        Zero1,
  output logic [31:0] AluBusA,
  output logic [31:0] AluBusB,
  output logic [3:0]  AluCtrl,
  input  logic [31:0] AluBusW,
  input  logic        AluZero
);

  localparam int CW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_t;

  state_t          state_reg, state_next;
  logic            last_gnt_reg, last_gnt_next;
  logic [CW-1:0]   lock_cnt_reg, lock_cnt_next;
  logic            gnt0, gnt1;
  logic            hold0, hold1, at_limit;

  assign at_limit = (lock_cnt_reg == CW'(MAX_LOCK));
  assign hold0    = (state_reg == LOCKED0) && Req0;
  assign hold1    = (state_reg == LOCKED1) && Req1;

  // A locked holder that has dropped Req behaves exactly like UNLOCKED.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (hold0) begin
      if (Req1 && at_limit) gnt1 = 1'b1;
      else                  gnt0 = 1'b1;
    end else if (hold1) begin
      if (Req0 && at_limit) gnt0 = 1'b1;
      else                  gnt1 = 1'b1;
    end else if (Req0 && Req1) begin
      gnt0 = last_gnt_reg;
      gnt1 = ~last_gnt_reg;
    end else begin
      gnt0 = Req0;
      gnt1 = Req1;
    end
  end

  always_comb begin
    state_next    = UNLOCKED;
    lock_cnt_next = '0;
    last_gnt_next = last_gnt_reg;
    if (gnt0) begin
      last_gnt_next = 1'b0;
      if (Lock0) begin
        state_next = LOCKED0;
        if (state_reg != LOCKED0) lock_cnt_next = CW'(1);
        else if (at_limit)        lock_cnt_next = lock_cnt_reg;
        else                      lock_cnt_next = lock_cnt_reg + CW'(1);
      end
    end else if (gnt1) begin
      last_gnt_next = 1'b1;
      if (Lock1) begin
        state_next = LOCKED1;
        if (state_reg != LOCKED1) lock_cnt_next = CW'(1);
        else if (at_limit)        lock_cnt_next = lock_cnt_reg;
        else                      lock_cnt_next = lock_cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= UNLOCKED;
      last_gnt_reg <= 1'b1;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  assign Gnt0 = gnt0;
  assign Gnt1 = gnt1;

  // Idle ALU sees zero operands and the AND code.
  always_comb begin
    AluBusA = '0;
    AluBusB = '0;
    AluCtrl = 4'b0000;
    if (gnt0) begin
      AluBusA = BusA0;
      AluBusB = BusB0;
      AluCtrl = ALUCtrl0;
    end else if (gnt1) begin
      AluBusA = BusA1;
      AluBusB = BusB1;
      AluCtrl = ALUCtrl1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Valid0 <= 1'b0;
      Valid1 <= 1'b0;
      BusW0  <= '0;
      BusW1  <= '0;
      Zero0  <= 1'b0;
      Zero1  <= 1'b0;
    end else begin
      Valid0 <= gnt0;
      Valid1 <= gnt1;
      if (gnt0) begin
        BusW0 <= AluBusW;
        Zero0 <= AluZero;
      end
      if (gnt1) begin
        BusW1 <= AluBusW;
        Zero1 <= AluZero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand sequences
// for reset/lock corners, and a randomized run against a behavioural model.
module tb_alu_arbiter;

  localparam int MAX_LOCK = 4;

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                         OP_SLL  = 4'b0011, OP_SRL  = 4'b0100, OP_SUB  = 4'b0110,
                         OP_SLT  = 4'b0111, OP_ADDU = 4'b1000, OP_SUBU = 4'b1001,
                         OP_XOR  = 4'b1010, OP_SLTU = 4'b1011, OP_NOR  = 4'b1100,
                         OP_SRA  = 4'b1101, OP_LUI  = 4'b1110;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req0, Req1, Lock0, Lock1;
  logic [31:0] BusA0, BusA1, BusB0, BusB1;
  logic [3:0]  ALUCtrl0, ALUCtrl1;
  logic        Gnt0, Gnt1, Valid0, Valid1, Zero0, Zero1;
  logic [31:0] BusW0, BusW1, AluBusA, AluBusB, AluBusW;
  logic [3:0]  AluCtrl;
  logic        AluZero;

  always #5 Clk = ~Clk;

  alu_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Lock0(Lock0), .Lock1(Lock1),
    .BusA0(BusA0), .BusA1(BusA1), .BusB0(BusB0), .BusB1(BusB1),
    .ALUCtrl0(ALUCtrl0), .ALUCtrl1(ALUCtrl1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Valid0(Valid0), .Valid1(Valid1),
    .BusW0(BusW0), .BusW1(BusW1), .Zero0(Zero0), .Zero1(Zero1),
    .AluBusA(AluBusA), .AluBusB(AluBusB), .AluCtrl(AluCtrl),
    .AluBusW(AluBusW), .AluZero(AluZero)
  );

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    case (c)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SLL:  return b << a[4:0];
      OP_SRL:  return b >> a[4:0];
      OP_SUB:  return a - b;
      OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      OP_ADDU: return a + b;
      OP_SUBU: return a - b;
      OP_XOR:  return a ^ b;
      OP_SLTU: return {31'b0, a < b};
      OP_NOR:  return ~(a | b);
      OP_SRA:  return $signed(b) >>> a[4:0];
      OP_LUI:  return {b[15:0], 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  // Stand-in for the shared ALU.
  assign AluBusW = alu_fn(AluBusA, AluBusB, AluCtrl);
  assign AluZero = (AluBusW == 32'h0);

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: who owns the lock, how many locked grants in a row,
  // who was granted last, and what each port should currently see.
  int          m_owner, m_streak, m_last, m_g;
  logic [31:0] m_w [2];
  logic        m_z [2];
  logic        m_v [2];

  task automatic model_reset();
    m_owner = -1; m_streak = 0; m_last = 1; m_g = -1;
    for (int p = 0; p < 2; p++) begin
      m_w[p] = 32'h0; m_z[p] = 1'b0; m_v[p] = 1'b0;
    end
  endtask

  function automatic int model_pick();
    bit r [2];
    r[0] = Req0; r[1] = Req1;
    if (m_owner >= 0 && r[m_owner]) begin
      if (r[1-m_owner] && m_streak >= MAX_LOCK) return 1 - m_owner;
      return m_owner;
    end
    if (r[0] && r[1]) return 1 - m_last;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  task automatic model_advance(int g);
    bit lk;
    if (g < 0) begin
      m_owner = -1; m_streak = 0;
    end else begin
      lk = (g == 0) ? Lock0 : Lock1;
      if (lk) begin
        m_streak = (m_owner == g) ? ((m_streak < MAX_LOCK) ? m_streak + 1 : MAX_LOCK) : 1;
        m_owner  = g;
      end else begin
        m_owner = -1; m_streak = 0;
      end
      m_last = g;
    end
  endtask

  // First half of a cycle: combinational outputs at the falling edge.
  task automatic half_a();
    logic [31:0] ea, eb;
    logic [3:0]  ec;
    @(negedge Clk);
    m_g = model_pick();
    chk("gnt0", Gnt0, m_g == 0);
    chk("gnt1", Gnt1, m_g == 1);
    ea = (m_g == 0) ? BusA0 : (m_g == 1) ? BusA1 : 32'h0;
    eb = (m_g == 0) ? BusB0 : (m_g == 1) ? BusB1 : 32'h0;
    ec = (m_g == 0) ? ALUCtrl0 : (m_g == 1) ? ALUCtrl1 : 4'b0000;
    chk("alu_bus_a", AluBusA, ea);
    chk("alu_bus_b", AluBusB, eb);
    chk("alu_ctrl", AluCtrl, ec);
    for (int p = 0; p < 2; p++) m_v[p] = (m_g == p);
    if (m_g == 0) m_w[0] = alu_fn(BusA0, BusB0, ALUCtrl0);
    if (m_g == 1) m_w[1] = alu_fn(BusA1, BusB1, ALUCtrl1);
    if (m_g >= 0) m_z[m_g] = (m_w[m_g] == 32'h0);
    model_advance(m_g);
  endtask

  // Second half: registered results just after the rising edge.
  task automatic half_b();
    @(posedge Clk);
    #1;
    chk("valid0", Valid0, m_v[0]);
    chk("valid1", Valid1, m_v[1]);
    chk("busw0", BusW0, m_w[0]);
    chk("busw1", BusW1, m_w[1]);
    chk("zero0", Zero0, m_z[0]);
    chk("zero1", Zero1, m_z[1]);
  endtask

  task automatic cycle();
    half_a();
    half_b();
  endtask

  task automatic idle_inputs();
    Req0 = 0; Req1 = 0; Lock0 = 0; Lock1 = 0;
    BusA0 = 0; BusB0 = 0; BusA1 = 0; BusB1 = 0;
    ALUCtrl0 = OP_AND; ALUCtrl1 = OP_AND;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit r0, r1, l0, l1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;
    bit e0, e1;
  } vec_t;

  function automatic vec_t mkv(int i, bit r0, bit r1, bit l0, bit l1, bit e0, bit e1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.e0 = e0; v.e1 = e1;
    v.a0 = 32'(i * 3 + 5); v.b0 = 32'd7; v.c0 = OP_ADD;
    if (i < 4) begin v.a1 = 32'd9; v.b1 = 32'd9; v.c1 = OP_SUB; end
    else begin v.a1 = 32'(100 + i); v.b1 = 32'd1; v.c1 = OP_ADDU; end
    return v;
  endfunction

  vec_t tbl [19];

  logic [3:0]  codes [14];
  bit          rq [2], lk [2], pend [2];
  logic [31:0] ra [2], rb [2];
  logic [3:0]  rc [2];
  int          wait_cnt [2];
  int          max_wait;

  initial begin
    tbl[0]  = mkv(0,  1, 1, 0, 0, 1, 0);
    tbl[1]  = mkv(1,  1, 1, 0, 0, 0, 1);
    tbl[2]  = mkv(2,  1, 1, 0, 0, 1, 0);
    tbl[3]  = mkv(3,  1, 1, 0, 0, 0, 1);
    tbl[4]  = mkv(4,  1, 0, 1, 0, 1, 0);
    tbl[5]  = mkv(5,  1, 0, 1, 0, 1, 0);
    tbl[6]  = mkv(6,  1, 1, 1, 0, 1, 0);
    tbl[7]  = mkv(7,  1, 1, 1, 0, 1, 0);
    tbl[8]  = mkv(8,  1, 1, 1, 0, 0, 1);
    tbl[9]  = mkv(9,  0, 1, 0, 1, 0, 1);
    tbl[10] = mkv(10, 0, 1, 0, 1, 0, 1);
    tbl[11] = mkv(11, 0, 1, 0, 1, 0, 1);
    tbl[12] = mkv(12, 0, 1, 0, 1, 0, 1);
    tbl[13] = mkv(13, 0, 1, 0, 1, 0, 1);
    tbl[14] = mkv(14, 1, 1, 0, 1, 1, 0);
    tbl[15] = mkv(15, 1, 0, 1, 0, 1, 0);
    tbl[16] = mkv(16, 1, 1, 1, 0, 1, 0);
    tbl[17] = mkv(17, 1, 0, 1, 0, 1, 0);
    tbl[18] = mkv(18, 0, 0, 0, 0, 0, 0);

    codes = '{OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRL, OP_SUB, OP_SLT,
              OP_ADDU, OP_SUBU, OP_XOR, OP_SLTU, OP_NOR, OP_SRA, OP_LUI};

    // Reset values, sampled while reset is held.
    idle_inputs();
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("rst valid0", Valid0, 0);  chk("rst valid1", Valid1, 0);
    chk("rst busw0", BusW0, 0);    chk("rst busw1", BusW1, 0);
    chk("rst zero0", Zero0, 0);    chk("rst zero1", Zero1, 0);
    chk("rst gnt0", Gnt0, 0);      chk("rst gnt1", Gnt1, 0);
    chk("rst alu_bus_a", AluBusA, 0);
    chk("rst alu_bus_b", AluBusB, 0);
    chk("rst alu_ctrl", AluCtrl, 0);
    do_reset();

    // Port 0 alone: 5 + 7.
    Req0 = 1; BusA0 = 5; BusB0 = 7; ALUCtrl0 = OP_ADD;
    half_a();
    chk("t1 gnt0", Gnt0, 1);
    chk("t1 alu_ctrl", AluCtrl, 4'b0010);
    half_b();
    chk("t1 valid0", Valid0, 1);
    chk("t1 busw0", BusW0, 12);
    chk("t1 zero0", Zero0, 0);
    chk("t1 valid1", Valid1, 0);

    // Directed table: alternation, lock limit, saturation, withdraw.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      Req0 = tbl[i].r0; Req1 = tbl[i].r1; Lock0 = tbl[i].l0; Lock1 = tbl[i].l1;
      BusA0 = tbl[i].a0; BusB0 = tbl[i].b0; ALUCtrl0 = tbl[i].c0;
      BusA1 = tbl[i].a1; BusB1 = tbl[i].b1; ALUCtrl1 = tbl[i].c1;
      half_a();
      chk("tbl gnt0", Gnt0, tbl[i].e0);
      chk("tbl gnt1", Gnt1, tbl[i].e1);
      half_b();
      if (tbl[i].e1 && i < 4) begin
        chk("tbl sub busw1", BusW1, 0);
        chk("tbl sub zero1", Zero1, 1);
      end
      $display("vec %0d req=%0d%0d lock=%0d%0d gnt=%0d%0d", i, tbl[i].r0, tbl[i].r1,
               tbl[i].l0, tbl[i].l1, Gnt0, Gnt1);
    end
    chk("withdraw busw1", BusW1, 114);
    chk("withdraw valid1", Valid1, 0);

    // Reset right after a locked grant to port 0.
    do_reset();
    Req0 = 1; Lock0 = 1; BusA0 = 20; BusB0 = 22; ALUCtrl0 = OP_ADD;
    cycle();
    chk("mid valid0 before", Valid0, 1);
    chk("mid busw0 before", BusW0, 42);
    idle_inputs();
    #2 Reset = 1'b1;
    #1;
    chk("mid valid0", Valid0, 0);
    chk("mid busw0", BusW0, 0);
    @(posedge Clk); #1 Reset = 1'b0;
    model_reset();
    Req0 = 1; Req1 = 1; BusA0 = 3; BusB0 = 4; ALUCtrl0 = OP_XOR;
    BusA1 = 8; BusB1 = 1; ALUCtrl1 = OP_SLL;
    half_a();
    chk("post rst gnt0", Gnt0, 1);
    half_b();
    chk("post rst busw0", BusW0, 7);
    idle_inputs();
    cycle();

    // Randomized traffic under the hold-until-granted protocol.
    do_reset();
    for (int p = 0; p < 2; p++) begin pend[p] = 0; wait_cnt[p] = 0; end
    max_wait = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          rq[p] = ($urandom_range(0, 99) < 60);
          lk[p] = ($urandom_range(0, 2) == 0);
          ra[p] = $urandom;
          rb[p] = ($urandom_range(0, 3) == 0) ? ra[p] : $urandom;
          rc[p] = codes[$urandom_range(0, 13)];
        end else if ($urandom_range(0, 19) == 0) begin
          rq[p] = 0;
        end
      end
      Req0 = rq[0]; Lock0 = lk[0]; BusA0 = ra[0]; BusB0 = rb[0]; ALUCtrl0 = rc[0];
      Req1 = rq[1]; Lock1 = lk[1]; BusA1 = ra[1]; BusB1 = rb[1]; ALUCtrl1 = rc[1];
      cycle();
      for (int p = 0; p < 2; p++) begin
        pend[p] = rq[p] && (m_g != p);
        wait_cnt[p] = pend[p] ? wait_cnt[p] + 1 : 0;
        if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
      end
    end
    chk("max wait bound", max_wait <= MAX_LOCK, 1);
    $display("random done max_wait=%0d", max_wait);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
